// File: rtl/game_state_sequencer.sv
// Frame-level game flow controller: folds per-pixel collisions into one event per type per frame
// and sequences IDLE/PLAY/DYING/RESPAWN/GAME_OVER/WIN with lives, score, freeze and pulses.
module game_state_sequencer #(
  parameter int unsigned INIT_LIVES     = 3,
  parameter int unsigned FRUIT_POINTS   = 10,
  parameter int unsigned SCORE_W        = 16,
  parameter int unsigned DEATH_FRAMES   = 60,
  parameter int unsigned RESPAWN_FRAMES = 45
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               startKey,
  input  logic               hit_enemy,
  input  logic               hit_fruit,
  input  logic               hit_goal,
  output logic [2:0]         state,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               freeze,
  output logic               respawn_pulse,
  output logic               fruit_pulse
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    RESPAWN   = 3'd3,
    GAME_OVER = 3'd4,
    WIN       = 3'd5
  } state_t;

  state_t       st;
  logic         enemy_seen, fruit_seen, goal_seen;
  logic [7:0]   frame_cnt;
  logic         start_req;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;

  assign state     = st;
  assign start_req = startKey && (st == IDLE || st == GAME_OVER || st == WIN);
  assign score_sum = {1'b0, score} + (SCORE_W+1)'(FRUIT_POINTS);
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  // freeze is updated alongside every state change so it tracks the new state without a decode lag
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      st            <= IDLE;
      lives         <= '0;
      score         <= '0;
      freeze        <= 1'b0;
      respawn_pulse <= 1'b0;
      fruit_pulse   <= 1'b0;
      enemy_seen    <= 1'b0;
      fruit_seen    <= 1'b0;
      goal_seen     <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      respawn_pulse <= 1'b0;
      fruit_pulse   <= 1'b0;
      if (start_req) begin
        st         <= PLAY;
        lives      <= 3'(INIT_LIVES);
        score      <= '0;
        freeze     <= 1'b0;
        enemy_seen <= 1'b0;
        fruit_seen <= 1'b0;
        goal_seen  <= 1'b0;
      end else if (startOfFrame) begin
        // hits on the frame boundary cycle belong to the frame that starts here
        enemy_seen <= hit_enemy;
        fruit_seen <= hit_fruit;
        goal_seen  <= hit_goal;
        case (st)
          PLAY: begin
            if (fruit_seen) begin
              score       <= score_sat;
              fruit_pulse <= 1'b1;
            end
            if (goal_seen) begin
              st     <= WIN;
              freeze <= 1'b1;
            end else if (enemy_seen) begin
              st        <= DYING;
              freeze    <= 1'b1;
              frame_cnt <= 8'(DEATH_FRAMES);
              if (lives != 3'd0) lives <= lives - 3'd1;
            end
          end
          DYING: begin
            if (frame_cnt == 8'd1) begin
              if (lives == 3'd0) begin
                st <= GAME_OVER;
              end else begin
                st            <= RESPAWN;
                freeze        <= 1'b0;
                frame_cnt     <= 8'(RESPAWN_FRAMES);
                respawn_pulse <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt - 8'd1;
            end
          end
          RESPAWN: begin
            if (fruit_seen) begin
              score       <= score_sat;
              fruit_pulse <= 1'b1;
            end
            if (frame_cnt == 8'd1) st <= PLAY;
            else                   frame_cnt <= frame_cnt - 8'd1;
          end
          default: ;
        endcase
      end else begin
        enemy_seen <= enemy_seen | hit_enemy;
        fruit_seen <= fruit_seen | hit_fruit;
        goal_seen  <= goal_seen  | hit_goal;
      end
    end
  end

endmodule

// File: tb/tb_game_state_sequencer.sv
// Self-checking bench for game_state_sequencer: vector table, directed corner sequences and a
// randomized run, all compared against a frame-level behavioural model.
module tb_game_state_sequencer;
  localparam int INIT_LIVES     = 3;
  localparam int FRUIT_POINTS   = 10;
  localparam int SCORE_W        = 16;
  localparam int DEATH_FRAMES   = 60;
  localparam int RESPAWN_FRAMES = 45;
  localparam int SCORE_MAX      = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic resetN, startOfFrame, startKey, hit_enemy, hit_fruit, hit_goal;
  logic [2:0] state, lives;
  logic [SCORE_W-1:0] score;
  logic freeze, respawn_pulse, fruit_pulse;

  int errors = 0;
  int checks = 0;

  // model: state as int (0 idle,1 play,2 dying,3 respawn,4 game over,5 win), frames elapsed in phase
  int m_st, m_lives, m_score, m_frames;
  bit m_frz, m_rp, m_fp, f_e, f_f, f_g;

  game_state_sequencer #(
    .INIT_LIVES(INIT_LIVES), .FRUIT_POINTS(FRUIT_POINTS), .SCORE_W(SCORE_W),
    .DEATH_FRAMES(DEATH_FRAMES), .RESPAWN_FRAMES(RESPAWN_FRAMES)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startKey(startKey),
    .hit_enemy(hit_enemy), .hit_fruit(hit_fruit), .hit_goal(hit_goal),
    .state(state), .lives(lives), .score(score), .freeze(freeze),
    .respawn_pulse(respawn_pulse), .fruit_pulse(fruit_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit sof, key, he, hf, hg;
    int st, lv, sc;
    bit frz, rp, fp;
  } vec_t;
  vec_t vt[$];

  function automatic logic [24:0] dut_word();
    return {state, lives, score, freeze, respawn_pulse, fruit_pulse};
  endfunction

  function automatic logic [24:0] model_word();
    return {3'(m_st), 3'(m_lives), 16'(m_score), m_frz, m_rp, m_fp};
  endfunction

  task automatic cmp(string name, logic [24:0] got, logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (state,lives,score,frz,rp,fp)", name, got, exp);
    end
  endtask

  task automatic expect_out(string name, int st, int lv, int sc);
    checks++;
    if (state !== 3'(st) || lives !== 3'(lv) || score !== 16'(sc)) begin
      errors++;
      $display("FAIL %s got st=%0d lives=%0d score=%0d exp st=%0d lives=%0d score=%0d",
               name, state, lives, score, st, lv, sc);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_lives = 0; m_score = 0; m_frames = 0;
    m_frz = 0; m_rp = 0; m_fp = 0; f_e = 0; f_f = 0; f_g = 0;
  endtask

  task automatic model_clk();
    m_rp = 0; m_fp = 0;
    if (startKey && (m_st == 0 || m_st == 4 || m_st == 5)) begin
      m_st = 1; m_lives = INIT_LIVES; m_score = 0;
      f_e = 0; f_f = 0; f_g = 0;
    end else if (startOfFrame) begin
      if ((m_st == 1 || m_st == 3) && f_f) begin
        m_score = (m_score + FRUIT_POINTS > SCORE_MAX) ? SCORE_MAX : m_score + FRUIT_POINTS;
        m_fp = 1;
      end
      if (m_st == 1) begin
        if (f_g) m_st = 5;
        else if (f_e) begin
          m_st = 2; m_frames = 0;
          if (m_lives > 0) m_lives = m_lives - 1;
        end
      end else if (m_st == 2) begin
        m_frames++;
        if (m_frames == DEATH_FRAMES) begin
          if (m_lives == 0) m_st = 4;
          else begin m_st = 3; m_frames = 0; m_rp = 1; end
        end
      end else if (m_st == 3) begin
        m_frames++;
        if (m_frames == RESPAWN_FRAMES) m_st = 1;
      end
      f_e = hit_enemy; f_f = hit_fruit; f_g = hit_goal;
    end else begin
      f_e |= hit_enemy; f_f |= hit_fruit; f_g |= hit_goal;
    end
    m_frz = (m_st == 2 || m_st == 4 || m_st == 5);
  endtask

  task automatic step(bit sof, bit key, bit he, bit hf, bit hg);
    startOfFrame = sof; startKey = key; hit_enemy = he; hit_fruit = hf; hit_goal = hg;
    @(posedge clk);
    model_clk();
    #1;
    cmp("model", dut_word(), model_word());
  endtask

  task automatic frame(bit he, bit hf, bit hg);
    step(0, 0, he, hf, hg);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  task automatic frames(int n, bit he, bit hf, bit hg);
    for (int i = 0; i < n; i++) frame(he, hf, hg);
  endtask

  initial begin
    resetN = 0; startOfFrame = 0; startKey = 0; hit_enemy = 0; hit_fruit = 0; hit_goal = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_state", dut_word(), 25'd0);
    resetN = 1;

    //             sof key he hf hg  st lv sc  frz rp fp
    vt.push_back('{0, 0, 1, 0, 0,   0, 0, 0,  0, 0, 0});
    vt.push_back('{1, 0, 1, 0, 0,   0, 0, 0,  0, 0, 0});
    vt.push_back('{0, 1, 0, 0, 0,   1, 3, 0,  0, 0, 0});
    vt.push_back('{0, 0, 0, 1, 0,   1, 3, 0,  0, 0, 0});
    vt.push_back('{0, 0, 0, 1, 0,   1, 3, 0,  0, 0, 0});
    vt.push_back('{1, 0, 0, 0, 0,   1, 3, 10, 0, 0, 1});
    vt.push_back('{0, 0, 0, 0, 0,   1, 3, 10, 0, 0, 0});
    vt.push_back('{1, 0, 0, 0, 0,   1, 3, 10, 0, 0, 0});
    vt.push_back('{0, 0, 1, 1, 0,   1, 3, 10, 0, 0, 0});
    vt.push_back('{0, 1, 0, 0, 0,   1, 3, 10, 0, 0, 0});
    vt.push_back('{1, 0, 0, 0, 0,   2, 2, 20, 1, 0, 1});
    vt.push_back('{0, 1, 1, 0, 0,   2, 2, 20, 1, 0, 0});
    vt.push_back('{1, 0, 1, 0, 0,   2, 2, 20, 1, 0, 0});
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].sof, vt[i].key, vt[i].he, vt[i].hf, vt[i].hg);
      cmp($sformatf("vec%0d", i), dut_word(),
          {3'(vt[i].st), 3'(vt[i].lv), 16'(vt[i].sc), vt[i].frz, vt[i].rp, vt[i].fp});
    end

    // remainder of DYING: exits on the 60th boundary
    frames(DEATH_FRAMES - 2, 1, 0, 0);
    expect_out("dying_hold", 2, 2, 20);
    frame(0, 0, 0);
    cmp("respawn_entry", dut_word(), {3'd3, 3'd2, 16'd20, 1'b0, 1'b1, 1'b0});
    step(0, 0, 0, 0, 0);
    cmp("respawn_pulse_end", dut_word(), {3'd3, 3'd2, 16'd20, 1'b0, 1'b0, 1'b0});
    frame(1, 1, 1);
    expect_out("respawn_fruit", 3, 2, 30);
    frames(RESPAWN_FRAMES - 2, 1, 0, 1);
    expect_out("respawn_hold", 3, 2, 30);
    frame(0, 0, 0);
    expect_out("respawn_exit", 1, 2, 30);

    // enemy seen only on the boundary cycle is committed one frame later
    step(1, 0, 1, 0, 0);
    expect_out("sof_hit_deferred", 1, 2, 30);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_out("sof_hit_commit", 2, 1, 30);
    frames(DEATH_FRAMES + RESPAWN_FRAMES, 0, 0, 0);
    expect_out("second_recover", 1, 1, 30);
    frame(1, 0, 0);
    frames(DEATH_FRAMES, 0, 0, 0);
    cmp("game_over", dut_word(), {3'd4, 3'd0, 16'd30, 1'b1, 1'b0, 1'b0});
    frame(0, 1, 0);
    expect_out("game_over_hold", 4, 0, 30);
    step(0, 1, 0, 0, 0);
    cmp("restart", dut_word(), {3'd1, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0});

    // goal outranks enemy; fruit in the same frame still counts
    frame(1, 1, 1);
    cmp("win", dut_word(), {3'd5, 3'd3, 16'd10, 1'b1, 1'b0, 1'b1});
    step(1, 1, 0, 1, 0);
    cmp("start_on_sof", dut_word(), {3'd1, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0});

    // asynchronous reset in the middle of DYING
    frame(1, 0, 0);
    frames(5, 0, 0, 0);
    expect_out("pre_reset", 2, 2, 0);
    #2 resetN = 0;
    #1;
    cmp("async_reset", dut_word(), 25'd0);
    model_reset();
    @(negedge clk);
    resetN = 1;

    // score saturation
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 6553; i++) begin
      step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
    end
    expect_out("score_65530", 1, 3, 65530);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    expect_out("score_sat", 1, 3, SCORE_MAX);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    expect_out("score_sat_hold", 1, 3, SCORE_MAX);

    // randomized run against the model
    for (int i = 0; i < 15000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 127) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
